display_scan_driver: RTL and testbench

//   Parametrised, time-multiplexed BCD to seven-segment driver for the microwave timer display.
//   It generalises the three fixed per-digit decoders into one scanned segment bus with N digit enables.

---
 rtl/display_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_display_scan_driver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/display_scan_driver.sv
// Time-multiplexed BCD to seven-segment driver: scans NUM_DIGITS digits over one
// shared segment bus, with frame-coherent snapshot loading, leading-zero blanking and blink.
module display_scan_driver #(
  parameter int NUM_DIGITS   = 3,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit AN_ACT_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              segs,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DISP_W = 4 * NUM_DIGITS;

  localparam logic [6:0]            SEGS_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACT_LOW ? {NUM_DIGITS{1'b1}} : '0;

  // Active-high {g,f,e,d,c,b,a}; any non-decimal code shows a dash.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DISP_W-1:0]     shadow_q, shadow_d;
  logic [DISP_W-1:0]     disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  hidden_q, hidden_d;
  logic [6:0]            segs_q, segs_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic scan_wrap;
  logic frame_end;

  // Scan timing: digit dwell counter and digit index.
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    frame_end  = scan_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_wrap) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end
  end

  // Snapshot handshake: the display copy only changes on a frame boundary, and a
  // load landing in that same cycle is held for the following boundary.
  always_comb begin
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = bcd_in;
      pending_d = 1'b1;
    end
  end

  // Blink phase advances per frame; disabling blink snaps back to visible.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    hidden_d    = hidden_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      hidden_d    = 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        hidden_d    = ~hidden_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  logic [NUM_DIGITS-1:0] zero_from;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [6:0]            seg_raw;
  logic                  all_zero;

  // Output decode: zero_from[k] means digit k and every higher digit are zero.
  always_comb begin
    zero_from = '0;
    all_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero && (disp_q[4*k +: 4] == 4'd0);
      zero_from[k] = all_zero;
    end

    an_onehot = '0;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        an_onehot[k] = 1'b1;
        cur_digit    = disp_q[4*k +: 4];
        cur_blank    = (blank_lz && (k != 0) && zero_from[k]) ||
                       (hidden_q && blink_en && blink_mask[k]);
      end
    end

    seg_raw = cur_blank ? 7'h00 : seg_encode(cur_digit);
    segs_d  = seg_raw ^ {7{SEG_ACT_LOW}};
    an_d    = an_onehot ^ {NUM_DIGITS{AN_ACT_LOW}};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      disp_q      <= '0;
      pending_q   <= 1'b0;
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
      segs_q      <= SEGS_OFF;
      an_q        <= AN_OFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      disp_q      <= disp_d;
      pending_q   <= pending_d;
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
      segs_q      <= segs_d;
      an_q        <= an_d;
    end
  end

  assign segs           = segs_q;
  assign an             = an_q;
  assign frame_done     = frame_end;
  assign update_pending = pending_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver: 3 digits, 4-clk dwell, 2-frame blink, active-high pins.
module tb_display_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic        blink_en;
  logic [2:0]  blink_mask;
  logic [6:0]  segs;
  logic [2:0]  an;
  logic        frame_done;
  logic        update_pending;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  display_scan_driver #(
    .NUM_DIGITS  (3),
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2),
    .SEG_ACT_LOW (1'b0),
    .AN_ACT_LOW  (1'b0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bcd_in        (bcd_in),
    .load          (load),
    .blank_lz      (blank_lz),
    .blink_en      (blink_en),
    .blink_mask    (blink_mask),
    .segs          (segs),
    .an            (an),
    .frame_done    (frame_done),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  // One rising edge, then settle on the falling edge; cyc counts edges since reset release.
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic goto(input int s);
    while (cyc < s) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_digit(input string tag, input logic [31:0] an_exp, input logic [31:0] seg_exp);
    chk({tag, ".an"}, 32'(an), an_exp);
    chk({tag, ".segs"}, 32'(segs), seg_exp);
  endtask

  task automatic do_load(input logic [11:0] v);
    bcd_in = v;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bcd_in = '0; load = 1'b0;
    blank_lz = 1'b0; blink_en = 1'b0; blink_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst.segs", 32'(segs), 32'h00);
    chk("rst.an", 32'(an), 32'h0);
    chk("rst.frame_done", 32'(frame_done), 32'h0);
    chk("rst.pending", 32'(update_pending), 32'h0);

    rst_n = 1'b1; cyc = 0;
    step();   chk_digit("first_drive", 32'b001, 32'h3F);
    goto(4);  chk_digit("dwell_end", 32'b001, 32'h3F);
    goto(5);  chk_digit("digit1", 32'b010, 32'h3F);
    goto(9);  chk_digit("digit2", 32'b100, 32'h3F);
    goto(10); chk("fd_before", 32'(frame_done), 32'h0);
    goto(11); chk("fd_pulse", 32'(frame_done), 32'h1);
    goto(12); chk("fd_after", 32'(frame_done), 32'h0);
    goto(13); chk_digit("wrap", 32'b001, 32'h3F);

    do_load(12'h259);
    chk("load259.pending", 32'(update_pending), 32'h1);
    chk("load259.no_tear", 32'(segs), 32'h3F);
    goto(23); chk("load259.fd", 32'(frame_done), 32'h1);
    chk("load259.still_pending", 32'(update_pending), 32'h1);
    goto(24); chk("load259.cleared", 32'(update_pending), 32'h0);
    goto(25); chk_digit("v259.d0", 32'b001, 32'h6F);
    goto(29); chk_digit("v259.d1", 32'b010, 32'h6D);
    goto(33); chk_digit("v259.d2", 32'b100, 32'h5B);

    goto(36); blank_lz = 1'b1;
    do_load(12'h007);
    goto(49); chk_digit("lz007.d0", 32'b001, 32'h07);
    goto(53); chk_digit("lz007.d1", 32'b010, 32'h00);
    goto(57); chk_digit("lz007.d2", 32'b100, 32'h00);
    do_load(12'h000);
    goto(61); chk_digit("lz000.d0", 32'b001, 32'h3F);
    goto(65); chk_digit("lz000.d1", 32'b010, 32'h00);
    goto(69); chk_digit("lz000.d2", 32'b100, 32'h00);

    do_load(12'h0A3);
    goto(73); chk_digit("inv.d0", 32'b001, 32'h4F);
    goto(77); chk_digit("inv.d1", 32'b010, 32'h40);
    goto(81); chk_digit("inv.d2", 32'b100, 32'h00);

    blink_en = 1'b1; blink_mask = 3'b110;
    do_load(12'h130);
    goto(85);  chk_digit("blk.vis.d0", 32'b001, 32'h3F);
    goto(89);  chk_digit("blk.vis.d1", 32'b010, 32'h4F);
    goto(93);  chk_digit("blk.vis.d2", 32'b100, 32'h06);
    goto(97);  chk_digit("blk.hid.d0", 32'b001, 32'h3F);
    goto(101); chk_digit("blk.hid.d1", 32'b010, 32'h00);
    goto(105); chk_digit("blk.hid.d2", 32'b100, 32'h00);
    goto(113); chk_digit("blk.hid2.d1", 32'b010, 32'h00);
    goto(125); chk_digit("blk.vis2.d1", 32'b010, 32'h4F);
    goto(129); chk_digit("blk.vis2.d2", 32'b100, 32'h06);
    goto(149); chk_digit("blk.hid3.d1", 32'b010, 32'h00);
    blink_en = 1'b0;
    step();    chk_digit("blk.off", 32'b010, 32'h4F);

    goto(160); do_load(12'h482);
    chk("bnd.pending", 32'(update_pending), 32'h1);
    goto(167); chk("bnd.fd", 32'(frame_done), 32'h1);
    do_load(12'h765);
    goto(169); chk("bnd.still_pending", 32'(update_pending), 32'h1);
    chk_digit("bnd.old.d0", 32'b001, 32'h5B);
    goto(173); chk_digit("bnd.old.d1", 32'b010, 32'h7F);
    goto(177); chk_digit("bnd.old.d2", 32'b100, 32'h66);
    goto(180); chk("bnd.cleared", 32'(update_pending), 32'h0);
    goto(181); chk_digit("bnd.new.d0", 32'b001, 32'h6D);

    goto(185); do_load(12'h111);
    chk("arst.pre_pending", 32'(update_pending), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.segs", 32'(segs), 32'h00);
    chk("arst.an", 32'(an), 32'h0);
    chk("arst.pending", 32'(update_pending), 32'h0);
    chk("arst.fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; cyc = 0;
    step();   chk_digit("arst.first", 32'b001, 32'h3F);
    goto(13); chk_digit("arst.discard.d0", 32'b001, 32'h3F);
    chk("arst.discard.pending", 32'(update_pending), 32'h0);
    goto(17); chk_digit("arst.discard.d1", 32'b010, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
